seq_restoring_divider: RTL and testbench

- Sequential unsigned divider; the inverse operation of the team's 4x4 Braun array multiplier.
- Takes an 8-bit dividend and a 4-bit divisor, and returns an 8-bit quotient and a 4-bit remainder.
- Restoring algorithm, one quotient bit per clock.
- valid/ready handshake on both the input and output sides, so it can sit behind the multiplier datapath and share its operand buses.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_sub_stage.sv | 25 ++
 rtl/seq_restoring_divider.sv | 115 +++++++++++
 tb/tb_seq_restoring_divider.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   localparam int DIV_DIVIDEND_W = 8;
   localparam int DIV_DIVISOR_W  = 4;

   localparam logic [DIV_DIVIDEND_W-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: shift in the next dividend bit, try to subtract
// the divisor, keep the difference only when it did not borrow.
module div_sub_stage #(
   parameter int DIVISOR_W = 4
) (
   input  logic [DIVISOR_W:0]   pr_in,
   input  logic                 dividend_bit,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W:0]   pr_out,
   output logic                 q_bit
);

   logic [DIVISOR_W:0] shifted;
   logic [DIVISOR_W:0] trial;
   logic               borrow;

   assign shifted         = {pr_in[DIVISOR_W-1:0], dividend_bit};
   assign {borrow, trial} = {1'b0, shifted} - {2'b00, divisor};

   // A set pr MSB means the shifted value exceeds any divisor, so the bit is 1
   // and the modulo-wrapped trial is still the correct difference.
   assign q_bit  = pr_in[DIVISOR_W] | ~borrow;
   assign pr_out = q_bit ? trial : shifted;

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on the operand and result sides.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int DIVIDEND_W = DIV_DIVIDEND_W,
   parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both 1; the sender holds its data stable until that edge.

   localparam int CNT_W = $clog2(DIVIDEND_W) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

   div_state_e            state;
   logic [DIVIDEND_W-1:0] dividend_reg;
   logic [DIVIDEND_W-1:0] q_work;
   logic [DIVISOR_W-1:0]  divisor_reg;
   logic [DIVISOR_W:0]    pr;
   logic [CNT_W-1:0]      count;

   logic [DIVISOR_W:0]    pr_next;
   logic                  q_bit;

   div_sub_stage #(
      .DIVISOR_W (DIVISOR_W)
   ) u_sub_stage (
      .pr_in        (pr),
      .dividend_bit (dividend_reg[DIVIDEND_W-1]),
      .divisor      (divisor_reg),
      .pr_out       (pr_next),
      .q_bit        (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         quotient     <= '0;
         remainder    <= '0;
         div_by_zero  <= 1'b0;
         dividend_reg <= '0;
         q_work       <= '0;
         divisor_reg  <= '0;
         pr           <= '0;
         count        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  dividend_reg <= dividend;
                  divisor_reg  <= divisor;
                  pr           <= '0;
                  q_work       <= '0;
                  count        <= '0;
                  in_ready     <= 1'b0;
                  if (divisor != '0) begin
                     state <= CALC;
                  end else begin
                     state       <= DONE;
                     quotient    <= DIVIDEND_W'(DIV_ZERO_QUOTIENT);
                     remainder   <= '0;
                     div_by_zero <= 1'b1;
                  end
               end
            end

            CALC: begin
               pr           <= pr_next;
               dividend_reg <= {dividend_reg[DIVIDEND_W-2:0], 1'b0};
               q_work       <= {q_work[DIVIDEND_W-2:0], q_bit};
               count        <= count + 1'b1;
               if (count == LAST_STEP) begin
                  state       <= DONE;
                  quotient    <= {q_work[DIVIDEND_W-2:0], q_bit};
                  remainder   <= pr_next[DIVISOR_W-1:0];
                  div_by_zero <= 1'b0;
               end
            end

            DONE: begin
               // Results settle on DONE entry; out_valid follows one edge later.
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and sweep bench for seq_restoring_divider with a scoreboard queue.
module tb_seq_restoring_divider;

   localparam int DW = 8;
   localparam int VW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] dividend = '0;
   logic [VW-1:0] divisor = '0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;

   int checks = 0;
   int failures = 0;

   logic [DW+VW:0] exp_q[$];

   logic [DW-1:0] res_q;
   logic [VW-1:0] res_r;
   logic          res_z;
   int            res_lat;

   seq_restoring_divider dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Issue one operation; caller is aligned #1 after a rising edge.
   task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input int hold, input bit pulse_in, input bit full);
      if (full) check("in_ready_idle", in_ready, 1);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = DW'($urandom);
      divisor  = VW'($urandom);
      res_lat = 0;
      while (!out_valid && res_lat < 40) begin
         if (full) check("in_ready_busy", in_ready, 0);
         @(posedge clk); #1;
         res_lat++;
      end
      if (!out_valid) begin
         check("out_valid_timeout", out_valid, 1);
         return;
      end
      res_q = quotient;
      res_r = remainder;
      res_z = div_by_zero;
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         if (pulse_in) begin
            in_valid = 1'b1;
            dividend = 8'd10;
            divisor  = 4'd2;
         end
         @(posedge clk); #1;
         if (full) begin
            check("hold_valid", out_valid, 1);
            check("hold_q", quotient, res_q);
            check("hold_r", remainder, res_r);
            check("hold_z", div_by_zero, res_z);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (full) check("valid_drop", out_valid, 0);
   endtask

   task automatic expect_result(input string tag, input logic [DW-1:0] q,
                                input logic [VW-1:0] r, input logic z, input int lat);
      logic [DW+VW:0] e;
      exp_q.push_back({z, q, r});
      e = exp_q.pop_front();
      check({tag, "_q"}, res_q, e[VW +: DW]);
      check({tag, "_r"}, res_r, e[VW-1:0]);
      check({tag, "_z"}, res_z, e[DW+VW]);
      check({tag, "_lat"}, res_lat, lat);
   endtask

   initial begin
      logic [DW-1:0] a;
      logic [VW-1:0] b;
      // clock/reset
      #23 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_dbz", div_by_zero, 0);

      run_op(8'd200, 4'd7, 0, 1'b0, 1'b1);
      expect_result("d200_7", 8'd28, 4'd4, 1'b0, 9);
      run_op(8'd5, 4'd9, 0, 1'b0, 1'b1);
      expect_result("d5_9", 8'd0, 4'd5, 1'b0, 9);
      run_op(8'd255, 4'd1, 1, 1'b0, 1'b1);
      expect_result("d255_1", 8'd255, 4'd0, 1'b0, 9);
      run_op(8'd225, 4'd15, 0, 1'b0, 1'b1);
      expect_result("d225_15", 8'd15, 4'd0, 1'b0, 9);
      run_op(8'd100, 4'd0, 2, 1'b0, 1'b1);
      expect_result("d100_0", 8'd255, 4'd0, 1'b1, 1);
      run_op(8'd9, 4'd3, 0, 1'b0, 1'b1);
      expect_result("d9_3", 8'd3, 4'd0, 1'b0, 9);

      // Backpressure with a stray in_valid pulse that must be ignored.
      run_op(8'd77, 4'd6, 5, 1'b1, 1'b1);
      expect_result("d77_6", 8'd12, 4'd5, 1'b0, 9);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         check("no_ghost_valid", out_valid, 0);
      end
      check("idle_after_ghost", in_ready, 1);

      // Reset mid-calculation after four steps.
      dividend = 8'd200;
      divisor  = 4'd7;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("postrst_valid", out_valid, 0);
      check("postrst_ready", in_ready, 1);
      run_op(8'd50, 4'd5, 0, 1'b0, 1'b1);
      expect_result("d50_5", 8'd10, 4'd0, 1'b0, 9);

      // Exhaustive sweep with random result backpressure.
      for (int x = 0; x < 256; x++) begin
         for (int y = 0; y < 16; y++) begin
            a = DW'(x);
            b = VW'(y);
            run_op(a, b, $urandom_range(0, 2), 1'b0, 1'b0);
            if (b == '0) begin
               expect_result("sweep_dbz", 8'd255, 4'd0, 1'b1, 1);
            end else begin
               check("sweep_inv", 32'(res_q) * 32'(b) + 32'(res_r), 32'(a));
               check("sweep_rlt", 32'(res_r < b), 1);
               check("sweep_z", res_z, 0);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
